// File: rtl/number_spawn_pkg.sv
// Shared types, widths and difficulty tables for the falling-number spawn scheduler.
package number_spawn_pkg;

  localparam int unsigned LFSR_W                 = 10;
  localparam int unsigned COORD_W                = 11;
  localparam int unsigned CNT_W                  = 6;
  localparam int unsigned FIXED_POINT_MULTIPLIER = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    PICK = 2'd2,
    LOAD = 2'd3
  } spawn_state_e;

  // Spawn period in frames and X speed magnitude (x64 fixed point) per difficulty level
  localparam logic [CNT_W-1:0] PERIOD_LUT [4] = '{6'd60, 6'd45, 6'd30, 6'd20};
  localparam int unsigned SPEED_LUT [4] = '{FIXED_POINT_MULTIPLIER / 4,
                                            FIXED_POINT_MULTIPLIER * 3 / 8,
                                            FIXED_POINT_MULTIPLIER / 2,
                                            FIXED_POINT_MULTIPLIER * 3 / 4};

  function automatic logic [COORD_W-1:0] signed_speed(input logic [1:0] level,
                                                      input logic       positive);
    logic [COORD_W-1:0] mag;
    mag = COORD_W'(SPEED_LUT[level]);
    return positive ? mag : (~mag + COORD_W'(1));
  endfunction

endpackage

// File: rtl/number_spawn_scheduler_if.sv
// Game-side bus of the spawn scheduler: frame/level control in, mover slot control out.
interface number_spawn_scheduler_if #(
  parameter int unsigned N_SLOTS = 4
);
  logic                                          startOfFrame;
  logic                                          enable;
  logic [1:0]                                    level;
  logic [number_spawn_pkg::COORD_W*N_SLOTS-1:0]  slotTopY;
  logic [N_SLOTS-1:0]                            slotHit;
  logic [N_SLOTS-1:0]                            slotActive;
  logic [N_SLOTS-1:0]                            slotLoad;
  logic [number_spawn_pkg::COORD_W-1:0]          loadX;
  logic [number_spawn_pkg::COORD_W-1:0]          loadSpeed;
  logic                                          spawnMissed;

  modport master (
    output startOfFrame, enable, level, slotTopY, slotHit,
    input  slotActive, slotLoad, loadX, loadSpeed, spawnMissed
  );

  modport slave (
    input  startOfFrame, enable, level, slotTopY, slotHit,
    output slotActive, slotLoad, loadX, loadSpeed, spawnMissed
  );
endinterface

// File: rtl/number_spawn_lfsr.sv
// Free-running 10-bit Fibonacci LFSR (x^10 + x^7 + 1) used for start X and direction.
module number_spawn_lfsr
  import number_spawn_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 10'h2A5
) (
  input  logic              clk,
  input  logic              resetN,
  output logic [LFSR_W-1:0] o_value
);

  logic [LFSR_W-1:0] r_lfsr;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_lfsr <= SEED;
    else         r_lfsr <= {r_lfsr[LFSR_W-2:0], r_lfsr[9] ^ r_lfsr[6]};
  end

  assign o_value = r_lfsr;

endmodule

// File: rtl/number_spawn_scheduler.sv
// Decides when a falling number spawns, which mover slot it takes, its start X/speed,
// and retires slots that were hit or left the screen.
module number_spawn_scheduler
  import number_spawn_pkg::*;
#(
  parameter int unsigned       N_SLOTS   = 4,
  parameter int unsigned       X_MIN     = 32,
  parameter int unsigned       X_RANGE   = 512,
  parameter int                Y_LIMIT   = 479,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 10'h2A5
) (
  input  logic                        clk,
  input  logic                        resetN,
  number_spawn_scheduler_if.slave     bus
);

  localparam int unsigned IDX_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;

  spawn_state_e        r_state, w_state_next;
  logic [CNT_W-1:0]    r_frame_cnt;
  logic [N_SLOTS-1:0]  r_slot_active, r_slot_load;
  logic [COORD_W-1:0]  r_load_x, r_load_speed;
  logic                r_spawn_missed;

  logic [LFSR_W-1:0]   w_lfsr;
  logic [N_SLOTS-1:0]  w_retire;
  logic                w_free_found;
  logic [IDX_W-1:0]    w_free_idx;
  logic [CNT_W-1:0]    w_period_m1;
  logic                w_expiry;
  logic                w_do_load, w_miss;
  logic [31:0]         w_x_off;
  logic [COORD_W-1:0]  w_start_x;

  number_spawn_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .resetN  (resetN),
    .o_value (w_lfsr)
  );

  // A live slot retires on a hit, or at frame start when its top edge is off screen
  always_comb begin
    logic signed [COORD_W-1:0] w_top_y;
    w_retire = '0;
    w_top_y  = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_top_y     = $signed(bus.slotTopY[COORD_W*i +: COORD_W]);
      w_retire[i] = r_slot_active[i] &&
                    (bus.slotHit[i] ||
                     (bus.startOfFrame &&
                      ((w_top_y > $signed(COORD_W'(Y_LIMIT))) || w_top_y[COORD_W-1])));
    end
  end

  // Lowest-index free slot; a slot retiring this cycle is still marked active here
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!r_slot_active[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = IDX_W'(i);
      end
    end
  end

  assign w_period_m1 = PERIOD_LUT[bus.level] - CNT_W'(1);
  assign w_expiry    = bus.enable && bus.startOfFrame && (r_frame_cnt >= w_period_m1);
  assign w_x_off     = (32'(w_lfsr[8:0]) >= X_RANGE) ? (32'(w_lfsr[8:0]) - X_RANGE)
                                                     : 32'(w_lfsr[8:0]);
  assign w_start_x   = COORD_W'(X_MIN + w_x_off);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_frame_cnt <= '0;
    end else if (bus.enable && bus.startOfFrame) begin
      r_frame_cnt <= w_expiry ? '0 : r_frame_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_do_load    = 1'b0;
    w_miss       = 1'b0;
    case (r_state)
      IDLE: if (bus.enable) w_state_next = WAIT;
      WAIT: begin
        if (!bus.enable)   w_state_next = IDLE;
        else if (w_expiry) w_state_next = PICK;
      end
      PICK: begin
        if (!bus.enable) begin
          w_state_next = IDLE;
        end else if (w_free_found) begin
          w_state_next = LOAD;
          w_do_load    = 1'b1;
        end else begin
          w_state_next = WAIT;
          w_miss       = 1'b1;
        end
      end
      LOAD:    w_state_next = bus.enable ? WAIT : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // The load strobe itself marks the slot live on the following edge
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_slot_active  <= '0;
      r_slot_load    <= '0;
      r_load_x       <= '0;
      r_load_speed   <= '0;
      r_spawn_missed <= 1'b0;
    end else begin
      r_slot_active  <= (r_slot_active & ~w_retire) | r_slot_load;
      r_slot_load    <= w_do_load ? (N_SLOTS'(1) << w_free_idx) : '0;
      r_spawn_missed <= w_miss;
      if (w_do_load) begin
        r_load_x     <= w_start_x;
        r_load_speed <= signed_speed(bus.level, w_lfsr[9]);
      end
    end
  end

  assign bus.slotActive  = r_slot_active;
  assign bus.slotLoad    = r_slot_load;
  assign bus.loadX       = r_load_x;
  assign bus.loadSpeed   = r_load_speed;
  assign bus.spawnMissed = r_spawn_missed;

endmodule

// File: tb/tb_number_spawn_scheduler.sv
// Self-checking bench for number_spawn_scheduler: level table, fill/retire corner cases,
// random stress against a behavioural model, enable pause and reset during a load.
`timescale 1ns/1ps
module tb_number_spawn_scheduler;

  localparam int unsigned N     = 4;
  localparam int          FC    = 4;
  localparam int          XMIN  = 32;
  localparam int          XRNG  = 512;
  localparam int          YLIM  = 479;
  localparam logic [9:0]  SEED  = 10'h2A5;

  logic clk    = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  number_spawn_scheduler_if #(.N_SLOTS(N)) bus ();

  number_spawn_scheduler #(
    .N_SLOTS(N), .X_MIN(XMIN), .X_RANGE(XRNG), .Y_LIMIT(YLIM), .LFSR_SEED(SEED)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // stimulus state
  bit          sof, en;
  int          lvl;
  int          topy [N];
  bit [N-1:0]  hit;
  int          frames_sent, cyc_phase;
  int          load_frame_q[$], load_slot_q[$], miss_frame_q[$];

  // behavioural reference state
  int          m_phase;   // 0 off, 1 counting frames, 2 choosing slot, 3 strobing load
  int          m_cnt;
  bit [9:0]    m_lfsr;
  bit [N-1:0]  m_act, m_load;
  bit          m_miss;
  int          m_x, m_speed;
  int          per_tab [4] = '{60, 45, 30, 20};
  int          spd_tab [4] = '{16, 24, 32, 48};

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_bit(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int speed_now();
    return int'($signed(bus.loadSpeed));
  endfunction

  task automatic drive();
    bus.startOfFrame = sof;
    bus.enable       = en;
    bus.level        = 2'(lvl);
    bus.slotHit      = hit;
    for (int i = 0; i < N; i++) bus.slotTopY[11*i +: 11] = 11'(topy[i]);
  endtask

  // One clock of the reference model: computes what the outputs must be after the edge
  task automatic model_tick();
    bit [N-1:0] gone;
    int         slot;
    bit         expire;
    if (!resetN) begin
      m_phase = 0; m_cnt = 0; m_lfsr = SEED; m_act = '0; m_load = '0;
      m_miss = 0; m_x = 0; m_speed = 0;
      return;
    end
    for (int i = 0; i < N; i++)
      gone[i] = m_act[i] && (hit[i] || (sof && (topy[i] > YLIM || topy[i] < 0)));
    expire = en && sof && (m_cnt >= per_tab[lvl] - 1);
    if (en && sof) m_cnt = expire ? 0 : m_cnt + 1;
    slot = -1;
    for (int i = N - 1; i >= 0; i--) if (!m_act[i]) slot = i;
    m_act  = (m_act & ~gone) | m_load;
    m_load = '0;
    m_miss = 0;
    if (m_phase == 3)        m_phase = en ? 1 : 0;
    else if (!en)            m_phase = 0;
    else if (m_phase == 0)   m_phase = 1;
    else if (m_phase == 1) begin
      if (expire) m_phase = 2;
    end else if (slot < 0) begin
      m_miss  = 1;
      m_phase = 1;
    end else begin
      m_load[slot] = 1'b1;
      m_x          = XMIN + (int'(m_lfsr[8:0]) % XRNG);
      m_speed      = m_lfsr[9] ? spd_tab[lvl] : -spd_tab[lvl];
      m_phase      = 3;
    end
    m_lfsr = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
  endtask

  task automatic compare_all();
    check("active",    int'(bus.slotActive), int'(m_act));
    check("load",      int'(bus.slotLoad),   int'(m_load));
    check("missed",    int'(bus.spawnMissed), int'(m_miss));
    check("loadX",     int'(bus.loadX),      m_x);
    check("loadSpeed", speed_now(),          m_speed);
  endtask

  task automatic step();
    sof = (cyc_phase == 0);
    if (sof) frames_sent++;
    drive();
    model_tick();
    @(negedge clk);
    compare_all();
    #2;
    cyc_phase = (cyc_phase + 1) % FC;
    if (bus.slotLoad != '0) begin
      load_frame_q.push_back(frames_sent);
      load_slot_q.push_back(lowest_bit(bus.slotLoad));
    end
    if (bus.spawnMissed) miss_frame_q.push_back(frames_sent);
  endtask

  task automatic run_frames(input int n);
    repeat (n * FC) step();
  endtask

  task automatic clear_log();
    load_frame_q.delete();
    load_slot_q.delete();
    miss_frame_q.delete();
  endtask

  task automatic do_reset();
    resetN = 1'b0; en = 0; sof = 0; hit = '0; lvl = 0;
    for (int i = 0; i < N; i++) topy[i] = 100;
    drive();
    repeat (2) begin
      model_tick();
      @(negedge clk);
      compare_all();
      #2;
    end
    resetN = 1'b1;
    frames_sent = 0;
    cyc_phase   = 0;
    clear_log();
  endtask

  typedef struct {
    int lvl;
    int exp_frames;
    int exp_mag;
  } lvl_vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    lvl_vec_t vecs [4];
    int first, mag, ld, base, loads, s, x;
    int offs [6] = '{480, -1, 479, 0, 200, -300};

    vecs[0] = '{0, 60, 16};
    vecs[1] = '{1, 45, 24};
    vecs[2] = '{2, 30, 32};
    vecs[3] = '{3, 20, 48};

    do_reset();
    check("rst_active", int'(bus.slotActive), 0);
    check("rst_load",   int'(bus.slotLoad),   0);
    check("rst_missed", int'(bus.spawnMissed), 0);
    check("rst_loadX",  int'(bus.loadX),      0);
    check("rst_speed",  speed_now(),          0);

    // Period and speed magnitude per level, first load always goes to slot 0
    foreach (vecs[k]) begin
      do_reset();
      lvl = vecs[k].lvl;
      en  = 1;
      first = -1; mag = 0; ld = 0;
      for (int c = 0; c < FC * (vecs[k].exp_frames + 10) && first < 0; c++) begin
        step();
        if (bus.slotLoad != '0) begin
          first = frames_sent;
          s     = speed_now();
          mag   = (s < 0) ? -s : s;
          ld    = int'(bus.slotLoad);
        end
      end
      check("level_period_frames", first, vecs[k].exp_frames);
      check("level_speed_mag",     mag,   vecs[k].exp_mag);
      check("level_first_slot",    ld,    1);
      step();
      check("level_active_after",  int'(bus.slotActive), 1);
    end

    // Fill all slots at level 3, then a period with nowhere to go
    do_reset();
    lvl = 3;
    en  = 1;
    run_frames(100);
    check("fill_load_count", load_frame_q.size(), 4);
    if (load_frame_q.size() == 4)
      for (int i = 0; i < 4; i++) begin
        check("fill_load_frame", load_frame_q[i], 20 * (i + 1));
        check("fill_load_slot",  load_slot_q[i],  i);
      end
    check("full_miss_count", miss_frame_q.size(), 1);
    if (miss_frame_q.size() == 1) check("full_miss_frame", miss_frame_q[0], 100);

    // Slot 1 drops below the screen, then gets the next spawn
    topy[1] = 480;
    step();
    topy[1] = 100;
    check("offscreen_retire", int'(bus.slotActive), 4'b1101);
    repeat (FC - 1) step();
    clear_log();
    run_frames(19);
    check("refill_count", load_frame_q.size(), 1);
    if (load_frame_q.size() == 1) begin
      check("refill_frame", load_frame_q[0], 120);
      check("refill_slot",  load_slot_q[0],  1);
    end

    // Hit on slot 2 in the very cycle the slot is being chosen: retire wins
    run_frames(19);
    step();
    hit[2] = 1'b1;
    step();
    hit = '0;
    check("hit_in_pick_missed", int'(bus.spawnMissed), 1);
    check("hit_in_pick_active", int'(bus.slotActive),  4'b1011);
    check("hit_in_pick_noload", int'(bus.slotLoad),    0);

    // Random stress against the model
    do_reset();
    en    = 1;
    lvl   = $urandom_range(0, 3);
    loads = 0;
    for (int c = 0; c < 8000; c++) begin
      if ($urandom_range(0, 199) == 0) lvl = $urandom_range(0, 3);
      if (en && $urandom_range(0, 399) == 0) en = 0;
      else if (!en && $urandom_range(0, 39) == 0) en = 1;
      for (int i = 0; i < N; i++) hit[i] = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 31) == 0) topy[$urandom_range(0, N-1)] = offs[$urandom_range(0, 5)];
      else if ($urandom_range(0, 15) == 0) topy[$urandom_range(0, N-1)] = 100;
      step();
      hit = '0;
      if (bus.slotLoad != '0) begin
        loads++;
        x = int'(bus.loadX);
        s = speed_now();
        if (s < 0) s = -s;
        check("sweep_x_range", int'(x >= 32 && x <= 543), 1);
        check("sweep_speed_mag", int'(s == 16 || s == 24 || s == 32 || s == 48), 1);
      end
    end
    check("sweep_loads_seen", int'(loads > 20), 1);

    // Pause mid-period keeps the frame count; then reset lands during the load strobe
    do_reset();
    lvl = 0;
    en  = 1;
    run_frames(30);
    en = 0;
    run_frames(10);
    en   = 1;
    base = frames_sent;
    first = -1;
    for (int c = 0; c < FC * 40 && first < 0; c++) begin
      step();
      if (bus.slotLoad != '0) first = frames_sent - base;
    end
    check("resume_frames", first, 30);
    resetN = 1'b0;
    #1;
    check("rst_in_load_slotLoad", int'(bus.slotLoad),   0);
    check("rst_in_load_active",   int'(bus.slotActive), 0);
    check("rst_in_load_missed",   int'(bus.spawnMissed), 0);
    check("rst_in_load_loadX",    int'(bus.loadX),      0);
    check("rst_in_load_speed",    speed_now(),          0);
    do_reset();
    step();
    check("post_reset_active", int'(bus.slotActive), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
